// File: rtl/psum_deskew_collector.sv
// Collects the skewed partial-sum stream from the bottom PE row, realigns the
// columns into one vector per result and buffers aligned vectors in a small FIFO.
module psum_deskew_collector #(
    parameter int data_width         = 22,
    parameter int w_tile_column_size = 11,
    parameter int fifo_depth         = 4
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          in_valid,
    input  logic [2*data_width*w_tile_column_size-1:0]    in_sum,
    output logic                                          stall_req,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [2*data_width*w_tile_column_size-1:0]    out_data,
    output logic                                          overflow
);

    localparam int COLS  = w_tile_column_size;
    localparam int PW    = 2 * data_width;
    localparam int VW    = PW * COLS;
    localparam int DLY   = COLS - 1;
    localparam int PTR_W = $clog2(fifo_depth);
    localparam int CNT_W = $clog2(fifo_depth + 1);
    localparam int IFL_W = $clog2(COLS);

    logic [DLY-1:0]   r_vld;
    logic [IFL_W-1:0] r_inflight;
    logic [IFL_W-1:0] w_inflight_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [VW-1:0]    r_mem [fifo_depth];
    logic             r_overflow;
    logic [VW-1:0]    w_aligned;
    logic             w_push_req;
    logic             w_full;
    logic             w_pop;
    logic             w_push_acc;
    logic             w_drop;
    logic [31:0]      w_occupancy;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(fifo_depth - 1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // Column c waits COLS-1-c cycles so every column lands on the same edge.
    for (genvar c = 0; c < DLY; c++) begin : g_col
        localparam int D = DLY - c;
        logic [PW-1:0] r_chain [D];

        // Per-column delay chain.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k < D; k++) begin
                    r_chain[k] <= {PW{1'b0}};
                end
            end else begin
                r_chain[0] <= in_sum[c*PW +: PW];
                for (int k = 1; k < D; k++) begin
                    r_chain[k] <= r_chain[k-1];
                end
            end
        end

        assign w_aligned[c*PW +: PW] = r_chain[D-1];
    end
    assign w_aligned[DLY*PW +: PW] = in_sum[DLY*PW +: PW];

    assign w_push_req  = r_vld[DLY-1];
    assign out_valid   = (r_count != {CNT_W{1'b0}});
    assign out_data    = r_mem[r_rd_ptr];
    assign overflow    = r_overflow;
    assign w_occupancy = 32'(r_count) + 32'(r_inflight);
    assign stall_req   = (w_occupancy >= 32'(fifo_depth));

    // Push/pop arbitration; a full FIFO still takes a push when it pops the same edge.
    always_comb begin
        w_full     = (r_count == CNT_W'(fifo_depth));
        w_pop      = out_valid & out_ready;
        w_push_acc = w_push_req & (~w_full | w_pop);
        w_drop     = w_push_req & w_full & ~w_pop;
    end

    // Next occupancy of FIFO and of the deskew pipeline.
    always_comb begin
        w_count_nxt    = r_count;
        w_inflight_nxt = r_inflight;
        case ({w_push_acc, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
        case ({in_valid, w_push_req})
            2'b10:   w_inflight_nxt = r_inflight + IFL_W'(1);
            2'b01:   w_inflight_nxt = r_inflight - IFL_W'(1);
            default: w_inflight_nxt = r_inflight;
        endcase
    end

    // Valid shift register tracking vectors inside the deskew pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= {DLY{1'b0}};
        end else begin
            r_vld[0] <= in_valid;
            for (int k = 1; k < DLY; k++) begin
                r_vld[k] <= r_vld[k-1];
            end
        end
    end

    // Counters, pointers and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count    <= {CNT_W{1'b0}};
            r_inflight <= {IFL_W{1'b0}};
            r_wr_ptr   <= {PTR_W{1'b0}};
            r_rd_ptr   <= {PTR_W{1'b0}};
            r_overflow <= 1'b0;
        end else begin
            r_count    <= w_count_nxt;
            r_inflight <= w_inflight_nxt;
            if (w_push_acc) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Aligned-vector storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < fifo_depth; i++) begin
                r_mem[i] <= {VW{1'b0}};
            end
        end else if (w_push_acc) begin
            r_mem[r_wr_ptr] <= w_aligned;
        end
    end

endmodule
